// File: rtl/rx_unpack.sv
// rx_unpack: reassembles an 8-word node-info packet from a valid/ready word
// stream, validates the packet-type word and holds the decoded fields until
// the consumer acknowledges them. Malformed or stalled packets are dropped.
module rx_unpack #(
  parameter int unsigned           WORD_WIDTH = 16,
  parameter int unsigned           PKT_WORDS  = 8,
  parameter int unsigned           GAP_LIMIT  = 15,
  parameter logic [WORD_WIDTH-1:0] BCAST_ID   = {WORD_WIDTH{1'b1}}
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  rx_valid,
  input  logic [WORD_WIDTH-1:0] rx_data,
  output logic                  rx_ready,
  input  logic [WORD_WIDTH-1:0] myNodeID,
  input  logic                  pkt_ack,
  output logic                  pkt_valid,
  output logic                  pkt_err,
  output logic [WORD_WIDTH-1:0] fSourceID,
  output logic [WORD_WIDTH-1:0] fEnergyLeft,
  output logic [WORD_WIDTH-1:0] fQValue,
  output logic [WORD_WIDTH-1:0] fSourceHops,
  output logic [WORD_WIDTH-1:0] fDestinationID,
  output logic [WORD_WIDTH-1:0] fChosenCH,
  output logic [WORD_WIDTH-1:0] fHopsFromCH,
  output logic [2:0]            fPacketType,
  output logic                  iAmDestination,
  output logic                  iAmBroadcast
);

  localparam int unsigned     IdxW    = $clog2(PKT_WORDS);
  localparam int unsigned     GapW    = $clog2(GAP_LIMIT + 1);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(PKT_WORDS - 1);
  localparam logic [GapW-1:0] GapLast = GapW'(GAP_LIMIT - 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRecv = 2'd1;
  localparam logic [1:0] StHold = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [GapW-1:0]       gap_q, gap_d;
  logic [WORD_WIDTH-1:0] buf_q [PKT_WORDS];

  logic accept;
  logic commit;
  logic drop;
  logic type_ok;

  // Handshake: ready depends on state; held low while reset is asserted.
  always_comb begin
    rx_ready = 1'b0;
    if (!rst) begin
      case (state_q)
        StIdle:  rx_ready = en;
        StRecv:  rx_ready = 1'b1;
        default: rx_ready = 1'b0;
      endcase
    end
  end

  assign pkt_valid = (state_q == StHold);
  assign accept    = rx_valid && rx_ready;
  // Word 5 is already in the buffer by the time word 7 arrives.
  assign type_ok   = (buf_q[5][WORD_WIDTH-1:3] == '0) && (buf_q[5][2:0] != 3'b111);

  // Next-state: packet sequencing, gap timeout and commit/drop decisions.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    gap_d   = gap_q;
    commit  = 1'b0;
    drop    = 1'b0;
    case (state_q)
      StIdle: begin
        if (accept) begin
          idx_d   = IdxW'(1);
          gap_d   = '0;
          state_d = StRecv;
        end
      end
      StRecv: begin
        if (accept) begin
          gap_d = '0;
          if (idx_q == LastIdx) begin
            idx_d = '0;
            if (type_ok) begin
              commit  = 1'b1;
              state_d = StHold;
            end else begin
              drop    = 1'b1;
              state_d = StIdle;
            end
          end else begin
            idx_d = idx_q + IdxW'(1);
          end
        end else if (gap_q == GapLast) begin
          drop    = 1'b1;
          idx_d   = '0;
          gap_d   = '0;
          state_d = StIdle;
        end else begin
          gap_d = gap_q + GapW'(1);
        end
      end
      StHold: begin
        if (pkt_ack) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State, shadow buffer and committed output fields.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      idx_q          <= '0;
      gap_q          <= '0;
      pkt_err        <= 1'b0;
      for (int i = 0; i < PKT_WORDS; i++) buf_q[i] <= '0;
      fSourceID      <= '0;
      fEnergyLeft    <= '0;
      fQValue        <= '0;
      fSourceHops    <= '0;
      fDestinationID <= '0;
      fChosenCH      <= '0;
      fHopsFromCH    <= '0;
      fPacketType    <= 3'b111;
      iAmDestination <= 1'b0;
      iAmBroadcast   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      gap_q   <= gap_d;
      pkt_err <= drop;
      if (accept) buf_q[idx_q] <= rx_data;
      if (commit) begin
        // Word 7 is taken straight from the bus on the commit cycle.
        fSourceID      <= buf_q[0];
        fEnergyLeft    <= buf_q[1];
        fQValue        <= buf_q[2];
        fSourceHops    <= buf_q[3];
        fDestinationID <= buf_q[4];
        fPacketType    <= buf_q[5][2:0];
        fChosenCH      <= buf_q[6];
        fHopsFromCH    <= rx_data;
        iAmDestination <= (buf_q[4] == myNodeID);
        iAmBroadcast   <= (buf_q[4] == BCAST_ID);
      end
    end
  end

endmodule
